// File: rtl/sound_pkg.sv
// rtl/sound_pkg.sv - shared note codes, scheduler state type and default sizes
package sound_pkg;

  localparam int DEF_N_REQ = 3;
  localparam int DEF_DUR_W = 9;

  localparam logic [2:0] REST = 3'd0;
  localparam logic [2:0] FA   = 3'd1;
  localparam logic [2:0] RE   = 3'd2;
  localparam logic [2:0] SOL  = 3'd3;
  localparam logic [2:0] DO   = 3'd4;
  localparam logic [2:0] SIB  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } snd_state_t;

endpackage

// File: rtl/sound_sched_if.sv
// rtl/sound_sched_if.sv - requester note offers, ready and completion pulses
interface sound_sched_if
  import sound_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int DUR_W = DEF_DUR_W
);

  logic [N_REQ-1:0]       req_valid;
  logic [3*N_REQ-1:0]     req_note;
  logic [DUR_W*N_REQ-1:0] req_dur;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ-1:0]       done;
  logic [N_REQ-1:0]       abort;

  modport master (
    output req_valid, req_note, req_dur,
    input  req_ready, done, abort
  );

  modport slave (
    input  req_valid, req_note, req_dur,
    output req_ready, done, abort
  );

endinterface

// File: rtl/sound_prio_pick.sv
// rtl/sound_prio_pick.sv - lowest-index-first priority encoder with eligibility mask
module sound_prio_pick
  import sound_pkg::*;
#(
  parameter int N     = DEF_N_REQ,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     mask,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the top down so the lowest eligible index is the last one written
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && mask[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        idx      = IDX_W'(i);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sound_sched.sv
// rtl/sound_sched.sv - fixed-priority buzzer arbiter and ms-timed note sequencer
module sound_sched
  import sound_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int DUR_W   = DEF_DUR_W,
  parameter int GAP_MS  = 10,
  parameter int PREEMPT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick_ms,
  input  logic         enable,
  sound_sched_if.slave bus,
  output logic [2:0]   note_out,
  output logic         busy,
  output logic [1:0]   owner
);

  // A zero gap still needs a one-bit counter so the declaration stays legal
  localparam int GAP_W = (GAP_MS > 0) ? $clog2(GAP_MS + 1) : 1;

  snd_state_t       state;
  logic [DUR_W-1:0] remaining;
  logic [GAP_W-1:0] gap_cnt;

  logic [N_REQ-1:0] pick_mask;
  logic [N_REQ-1:0] grant;
  logic [1:0]       grant_idx;
  logic             grant_any;
  logic [2:0]       sel_note;
  logic [DUR_W-1:0] sel_dur;
  logic [DUR_W-1:0] load_dur;
  logic [N_REQ-1:0] owner_bit;

  // Eligible requesters: everyone in IDLE, only higher priority than the owner in PLAY
  always_comb begin
    pick_mask = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (enable && state == ST_IDLE) begin
        pick_mask[i] = 1'b1;
      end else if (enable && state == ST_PLAY && PREEMPT != 0 && i < int'(owner)) begin
        pick_mask[i] = 1'b1;
      end
    end
  end

  sound_prio_pick #(
    .N     (N_REQ),
    .IDX_W (2)
  ) u_pick (
    .req   (bus.req_valid),
    .mask  (pick_mask),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  assign bus.req_ready = grant;

  // Route the granted requester's note and duration; a zero duration still plays one tick
  always_comb begin
    sel_note = '0;
    sel_dur  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_note = bus.req_note[3*i +: 3];
        sel_dur  = bus.req_dur[DUR_W*i +: DUR_W];
      end
    end
    load_dur = (sel_dur == '0) ? DUR_W'(1) : sel_dur;
  end

  // One-hot form of the current owner for the done/abort pulses
  always_comb begin
    owner_bit = '0;
    for (int i = 0; i < N_REQ; i++) begin
      owner_bit[i] = (int'(owner) == i);
    end
  end

  // Sequencer: grant, per-tick note timing, preemption, post-note gap and enable drop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      note_out  <= REST;
      busy      <= 1'b0;
      owner     <= '0;
      bus.done  <= '0;
      bus.abort <= '0;
      remaining <= '0;
      gap_cnt   <= '0;
    end else begin
      bus.done  <= '0;
      bus.abort <= '0;
      if (!enable) begin
        if (state == ST_PLAY) begin
          bus.abort <= owner_bit;
        end
        state     <= ST_IDLE;
        note_out  <= REST;
        busy      <= 1'b0;
        remaining <= '0;
        gap_cnt   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (grant_any) begin
              owner     <= grant_idx;
              note_out  <= sel_note;
              remaining <= load_dur;
              busy      <= 1'b1;
              state     <= ST_PLAY;
            end
          end
          ST_PLAY: begin
            if (grant_any) begin
              // Preemption swaps notes at one edge; a coincident tick is dropped
              bus.abort <= owner_bit;
              owner     <= grant_idx;
              note_out  <= sel_note;
              remaining <= load_dur;
            end else if (tick_ms) begin
              if (remaining == DUR_W'(1)) begin
                bus.done  <= owner_bit;
                note_out  <= REST;
                remaining <= '0;
                gap_cnt   <= '0;
                if (GAP_MS == 0) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
                end else begin
                  state <= ST_GAP;
                end
              end else begin
                remaining <= remaining - 1'b1;
              end
            end
          end
          ST_GAP: begin
            if (tick_ms) begin
              if (gap_cnt == GAP_W'(GAP_MS - 1)) begin
                gap_cnt <= '0;
                busy    <= 1'b0;
                state   <= ST_IDLE;
              end else begin
                gap_cnt <= gap_cnt + 1'b1;
              end
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sound_sched.sv
// tb/tb_sound_sched.sv - directed and random checks of sound_sched against a note-level model
module tb_sound_sched;
  import sound_pkg::*;

  localparam int N  = 3;
  localparam int DW = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick_ms = 1'b0;
  logic enable = 1'b0;

  logic [N-1:0]    valid [2];
  logic [3*N-1:0]  note  [2];
  logic [DW*N-1:0] dur   [2];

  logic [2:0]   dnote  [2];
  logic         dbusy  [2];
  logic [1:0]   down   [2];
  logic [N-1:0] dready [2];
  logic [N-1:0] ddone  [2];
  logic [N-1:0] dabort [2];

  int checks = 0;
  int errors = 0;

  sound_sched_if #(.N_REQ(N), .DUR_W(DW)) bus0 ();
  sound_sched_if #(.N_REQ(N), .DUR_W(DW)) bus1 ();

  assign bus0.req_valid = valid[0];
  assign bus0.req_note  = note[0];
  assign bus0.req_dur   = dur[0];
  assign bus1.req_valid = valid[1];
  assign bus1.req_note  = note[1];
  assign bus1.req_dur   = dur[1];
  assign dready[0] = bus0.req_ready;
  assign ddone[0]  = bus0.done;
  assign dabort[0] = bus0.abort;
  assign dready[1] = bus1.req_ready;
  assign ddone[1]  = bus1.done;
  assign dabort[1] = bus1.abort;

  sound_sched #(.N_REQ(N), .DUR_W(DW), .GAP_MS(10), .PREEMPT(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .tick_ms(tick_ms), .enable(enable), .bus(bus0),
    .note_out(dnote[0]), .busy(dbusy[0]), .owner(down[0])
  );

  sound_sched #(.N_REQ(N), .DUR_W(DW), .GAP_MS(0), .PREEMPT(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .tick_ms(tick_ms), .enable(enable), .bus(bus1),
    .note_out(dnote[1]), .busy(dbusy[1]), .owner(down[1])
  );

  always #5 clk = ~clk;

  // Model: 0 silent/idle, 1 sounding a note, 2 in the silent gap
  int           ms    [2];
  int           mown  [2];
  int           mleft [2];
  int           mgap  [2];
  logic [2:0]   mnote [2];
  logic [N-1:0] mdone [2];
  logic [N-1:0] mabort[2];

  function automatic int gap_of(input int k);
    return (k == 0) ? 10 : 0;
  endfunction

  function automatic bit pre_of(input int k);
    return (k == 0);
  endfunction

  function automatic logic [N-1:0] exp_ready(input int k);
    logic [N-1:0] r;
    int lim;
    bit found;
    r = '0;
    found = 1'b0;
    lim = 0;
    if (rst_n && enable) begin
      if (ms[k] == 0) lim = N;
      else if (ms[k] == 1 && pre_of(k)) lim = mown[k];
    end
    for (int i = 0; i < N; i++) begin
      if (i < lim && valid[k][i] && !found) begin
        r[i] = 1'b1;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic model_step(input int k);
    logic [N-1:0] r;
    int j;
    int d;
    r = exp_ready(k);
    mdone[k] = '0;
    mabort[k] = '0;
    j = -1;
    for (int i = 0; i < N; i++) if (r[i] && j < 0) j = i;
    if (!enable) begin
      if (ms[k] == 1) mabort[k][mown[k]] = 1'b1;
      ms[k] = 0;
      mnote[k] = REST;
    end else if (j >= 0) begin
      if (ms[k] == 1) mabort[k][mown[k]] = 1'b1;
      d = int'(dur[k][DW*j +: DW]);
      mown[k] = j;
      mnote[k] = note[k][3*j +: 3];
      mleft[k] = (d > 0) ? d : 1;
      ms[k] = 1;
    end else if (tick_ms && ms[k] == 1) begin
      if (mleft[k] == 1) begin
        mdone[k][mown[k]] = 1'b1;
        mnote[k] = REST;
        mgap[k] = gap_of(k);
        ms[k] = (gap_of(k) > 0) ? 2 : 0;
      end else begin
        mleft[k] = mleft[k] - 1;
      end
    end else if (tick_ms && ms[k] == 2) begin
      mgap[k] = mgap[k] - 1;
      if (mgap[k] == 0) ms[k] = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advances on the same edges as the DUTs
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        ms[k] = 0; mown[k] = 0; mleft[k] = 0; mgap[k] = 0;
        mnote[k] = REST; mdone[k] = '0; mabort[k] = '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) model_step(k);
    end
  end

  // Every falling edge out of reset, both DUTs must agree with the model
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("d%0d_ready", k), 32'(dready[k]), 32'(exp_ready(k)));
        chk($sformatf("d%0d_note", k), 32'(dnote[k]), 32'(mnote[k]));
        chk($sformatf("d%0d_busy", k), 32'(dbusy[k]), 32'(ms[k] != 0));
        chk($sformatf("d%0d_done", k), 32'(ddone[k]), 32'(mdone[k]));
        chk($sformatf("d%0d_abort", k), 32'(dabort[k]), 32'(mabort[k]));
        if (ms[k] == 1) chk($sformatf("d%0d_owner", k), 32'(down[k]), 32'(mown[k]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_req(input int k, input int i, input int n, input int d);
    valid[k][i] = 1'b1;
    note[k][3*i +: 3] = n[2:0];
    dur[k][DW*i +: DW] = d[DW-1:0];
  endtask

  task automatic finish_gap(input int k);
    bit gone;
    gone = 1'b0;
    for (int c = 0; c < 40 && !gone; c++) begin
      tick_ms = 1'b1; step; tick_ms = 1'b0; smp;
      if (!dbusy[k]) gone = 1'b1;
    end
    chk("gap_end", 32'(gone), 32'd1);
    step;
  endtask

  task automatic play_count(input int d, input int exp_n, input string name);
    int n;
    bit seen;
    set_req(0, 0, FA, d);
    tick_ms = 1'b1;
    smp;
    chk({name, "_ready"}, 32'(dready[0]), 32'b001);
    step;
    valid[0] = '0;
    n = 0;
    seen = 1'b0;
    for (int c = 0; c < 600 && !seen; c++) begin
      @(posedge clk);
      n++;
      smp;
      if (ddone[0][0]) seen = 1'b1;
    end
    chk(name, 32'(n), 32'(exp_n));
    for (int c = 0; c < 20 && dbusy[0]; c++) smp;
    chk({name, "_idle"}, 32'(dbusy[0]), 32'd0);
    step;
    tick_ms = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] acc [2];
    for (int k = 0; k < 2; k++) begin
      valid[k] = '0; note[k] = '0; dur[k] = '0;
    end
    repeat (3) @(posedge clk);
    smp;
    chk("rst_note", 32'(dnote[0]), 32'd0);
    chk("rst_busy", 32'(dbusy[0]), 32'd0);
    chk("rst_owner", 32'(down[0]), 32'd0);
    chk("rst_done", 32'(ddone[0]), 32'd0);
    chk("rst_abort", 32'(dabort[0]), 32'd0);
    step;
    rst_n = 1'b1;
    enable = 1'b1;

    // FA for 3 ticks, then a 10-tick gap
    step;
    set_req(0, 0, FA, 3);
    smp;
    chk("t1_ready", 32'(dready[0]), 32'b001);
    step;
    valid[0] = '0;
    smp;
    chk("t1_note", 32'(dnote[0]), 32'd1);
    chk("t1_model_note", 32'(mnote[0]), 32'd1);
    chk("t1_busy", 32'(dbusy[0]), 32'd1);
    for (int t = 1; t <= 3; t++) begin
      tick_ms = 1'b1; step; tick_ms = 1'b0; smp;
      chk("t1_done", 32'(ddone[0]), (t == 3) ? 32'b001 : 32'b000);
      chk("t1_sound", 32'(dnote[0]), (t == 3) ? 32'd0 : 32'd1);
      step;
    end
    for (int t = 1; t <= 10; t++) begin
      tick_ms = 1'b1; step; tick_ms = 1'b0; smp;
      chk("t1_gap_busy", 32'(dbusy[0]), (t < 10) ? 32'd1 : 32'd0);
      chk("t1_gap_note", 32'(dnote[0]), 32'd0);
    end
    step;

    // req1 and req2 together: req1 first, req2 after note plus gap
    set_req(0, 1, RE, 2);
    set_req(0, 2, DO, 100);
    smp;
    chk("t2_ready", 32'(dready[0]), 32'b010);
    step;
    valid[0][1] = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      tick_ms = 1'b1; step; tick_ms = 1'b0; smp;
      chk("t2_wait", 32'(dready[0]), (t < 12) ? 32'b000 : 32'b100);
      step;
    end
    valid[0][2] = 1'b0;
    smp;
    chk("t2_note", 32'(dnote[0]), 32'd4);
    chk("t2_owner", 32'(down[0]), 32'd2);

    // req0 preempts req2 on a tick; note switches 4 -> 1 without silence
    step;
    for (int t = 1; t <= 39; t++) begin
      tick_ms = 1'b1; step; tick_ms = 1'b0; step;
    end
    tick_ms = 1'b1;
    set_req(0, 0, FA, 5);
    smp;
    chk("t3_ready", 32'(dready[0]), 32'b001);
    chk("t3_old_note", 32'(dnote[0]), 32'd4);
    step;
    tick_ms = 1'b0;
    valid[0] = '0;
    smp;
    chk("t3_abort", 32'(dabort[0]), 32'b100);
    chk("t3_new_note", 32'(dnote[0]), 32'd1);
    chk("t3_owner", 32'(down[0]), 32'd0);
    for (int t = 1; t <= 5; t++) begin
      tick_ms = 1'b1; step; tick_ms = 1'b0; smp;
      chk("t3_done", 32'(ddone[0]), (t == 5) ? 32'b001 : 32'b000);
    end
    finish_gap(0);

    // No preemption and no gap on the second instance
    set_req(1, 2, DO, 4);
    smp;
    chk("t4_ready", 32'(dready[1]), 32'b100);
    step;
    valid[1] = '0;
    tick_ms = 1'b1; step; tick_ms = 1'b0; step;
    tick_ms = 1'b1; step; tick_ms = 1'b0;
    set_req(1, 0, FA, 2);
    smp;
    chk("t4_hold", 32'(dready[1]), 32'b000);
    for (int t = 1; t <= 2; t++) begin
      tick_ms = 1'b1; step; tick_ms = 1'b0; smp;
      chk("t4_ready_after", 32'(dready[1]), (t == 2) ? 32'b001 : 32'b000);
      chk("t4_done2", 32'(ddone[1]), (t == 2) ? 32'b100 : 32'b000);
    end
    step;
    valid[1] = '0;
    smp;
    chk("t4_note", 32'(dnote[1]), 32'd1);
    tick_ms = 1'b1; step; step; tick_ms = 1'b0;
    smp;
    chk("t4_done0", 32'(ddone[1]), 32'b001);
    step;

    // Exact tick counts, with a tick in every grant cycle
    play_count(0, 1, "dur0");
    play_count(1, 1, "dur1");
    play_count(511, 511, "dur511");

    // Enable drop mid-note
    set_req(0, 1, SOL, 20);
    step;
    valid[0] = '0;
    tick_ms = 1'b1; step; step; step; tick_ms = 1'b0;
    set_req(0, 0, FA, 2);
    enable = 1'b0;
    smp;
    chk("t6_ready_low", 32'(dready[0]), 32'b000);
    step;
    smp;
    chk("t6_abort", 32'(dabort[0]), 32'b010);
    chk("t6_note", 32'(dnote[0]), 32'd0);
    chk("t6_busy", 32'(dbusy[0]), 32'd0);
    chk("t6_ready_held", 32'(dready[0]), 32'b000);
    step; step;
    enable = 1'b1;
    smp;
    chk("t6_ready_back", 32'(dready[0]), 32'b001);
    step;
    valid[0] = '0;
    smp;
    chk("t6_replay", 32'(dnote[0]), 32'd1);
    tick_ms = 1'b1; step; step; tick_ms = 1'b0;
    smp;
    chk("t6_done", 32'(ddone[0]), 32'b001);
    finish_gap(0);

    // Asynchronous reset in the middle of a gap
    set_req(0, 2, SIB, 1);
    step;
    valid[0] = '0;
    tick_ms = 1'b1; step; step; step; step; tick_ms = 1'b0;
    smp;
    chk("t7_busy", 32'(dbusy[0]), 32'd1);
    chk("t7_owner", 32'(down[0]), 32'd2);
    step;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_rst_note", 32'(dnote[0]), 32'd0);
    chk("t7_rst_busy", 32'(dbusy[0]), 32'd0);
    chk("t7_rst_owner", 32'(down[0]), 32'd0);
    chk("t7_rst_done", 32'(ddone[0]), 32'd0);
    chk("t7_rst_abort", 32'(dabort[0]), 32'd0);
    step;
    rst_n = 1'b1;

    // Random traffic on both instances, requesters honour the handshake
    for (int c = 0; c < 3000; c++) begin
      smp;
      for (int k = 0; k < 2; k++) acc[k] = dready[k] & valid[k];
      step;
      tick_ms = ($urandom_range(0, 3) == 0);
      if (enable) enable = ($urandom_range(0, 199) != 0);
      else enable = ($urandom_range(0, 2) == 0);
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < N; i++) begin
          if (acc[k][i]) valid[k][i] = 1'b0;
          if (!valid[k][i] && $urandom_range(0, 3) == 0) begin
            if ($urandom_range(0, 15) == 0) set_req(k, i, $urandom_range(0, 5), $urandom_range(10, 60));
            else set_req(k, i, $urandom_range(0, 5), $urandom_range(0, 9));
          end
        end
      end
    end
    smp;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sound_sched.md
# sound_sched

Arbiter and note sequencer that shares the single buzzer tone generator among several sound sources: keypad click, in-game melody and win/lose jingle. Each requester offers one note (code plus duration in ms) over a valid/ready handshake. The block grants by fixed priority, optionally preempts a lower-priority note, and times each note with the 1 kHz tick. It drives the note code consumed by the tone divider-select logic.

## Interface
- `N_REQ`, 3: number of requesters. Index 0 has the highest priority.
- `DUR_W`, 9: width of the per-note duration field, in ms.
- `GAP_MS`, 10: silent gap in ms inserted after every naturally finished note. 0 means no gap.
- `PREEMPT`, 1: 1 lets a higher-priority request abort the playing note.

- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `tick_ms`  in  1  one-cycle strobe at 1 kHz, synchronous to `clk`.
- `enable`  in  1  sound allowed (game state not OFF).
- `req_valid`  in  N_REQ  per-requester note offer.
- `req_note`  in  3*N_REQ  note code per requester. Slice i is bits [3i+2:3i].
- `req_dur`  in  DUR_W*N_REQ  duration in ms per requester.
- `req_ready`  out  N_REQ  one-hot accept, combinational.
- `done`  out  N_REQ  one-cycle pulse: the owner's note finished naturally.
- `abort`  out  N_REQ  one-cycle pulse: the owner's note was preempted or cancelled.
- `note_out`  out  3  note code to the tone generator. 0 = silence.
- `busy`  out  1  high in PLAY or GAP.
- `owner`  out  2  index of the current owner, valid while in PLAY.

## Operation
- States: IDLE, PLAY, GAP.
- **IDLE**
  - If `enable` and any `req_valid` is high, select the lowest valid index i and assert `req_ready[i]` in that cycle.
  - Sample `req_note[i]` and `req_dur[i]`, set `owner`=i and `remaining`=max(dur,1), then go to PLAY.
- **PLAY**
  - `note_out` = latched note. Code 0 is a legal timed rest.
  - On `tick_ms`, decrement `remaining`. When a tick arrives with `remaining`==1, pulse `done[owner]` and go to GAP (or to IDLE if GAP_MS==0).
  - Preemption: if PREEMPT=1 and `req_valid[j]` is high for some j < owner, the cycle does three things at once:
    - pulses `abort[owner]`;
    - asserts `req_ready[j]` for the lowest such j, and loads its note, duration and owner;
    - stays in PLAY, and no gap is inserted.
  - An equal- or lower-priority request waits with `req_ready` low.
- **GAP**
  - `note_out`=0. Count GAP_MS ticks, then go to IDLE.
  - GAP is not preemptible. Requests wait.
- **Handshake**
  - A requester holds valid, note and dur stable until it sees ready.
  - A ready pulse consumes exactly one note. The requester may present the next note in the following cycle.
- **enable low**
  - In any state, enable low forces IDLE on the next edge.
  - If the block was in PLAY, it pulses `abort[owner]`.
  - `req_ready` is held at 0 and `note_out` becomes 0 on the next edge.
- **Reset values:** state IDLE, `note_out`=0, `busy`=0, `owner`=0, `done`=0, `abort`=0, counters 0.
- **Arithmetic**
  - `remaining` is DUR_W bits and never underflows, because the decrement happens only while it is ≥1.
  - The gap counter is $clog2(GAP_MS+1) bits.

## Timing
- `req_ready` is combinational from state, `owner` and `req_valid`.
- `note_out`, `busy`, `owner`, `done` and `abort` are registered. The new note appears one cycle after the ready cycle.
- A `tick_ms` in the grant cycle is ignored because the counter is being loaded. A note therefore sounds for dur ticks: dur ms, within one tick period.
- Natural end to next grant takes GAP_MS ticks + 1 cycle. With GAP_MS=0, IDLE lasts one cycle before the next grant.
- Preemption: abort, ready and new note all take effect at the same edge, so `note_out` switches with no silent cycle.
- A tick and a preempt in the same cycle: the preempt wins, and the new duration loads without decrementing.
- Asynchronous reset mid-note: outputs reach reset values immediately, with no done or abort pulse.

## Structure
- Shared package `sound_pkg` holds:
  - note codes REST=0, FA=1, RE=2, SOL=3, DO=4, SIB=5;
  - the state enum `snd_state_t`;
  - the default N_REQ and DUR_W.
- Sub-module `sound_prio_pick`: parameterised lowest-index-first priority encoder with a mask input ("index < owner"), used for both the idle grant and the preemption check.

## Test plan
- Reset, then req0 valid with FA, dur 3 → `req_ready[0]` in the same cycle; `note_out`=1 from the next cycle for 3 ticks; `done[0]` pulse; 10 ticks of `note_out`=0; `busy` falls.
- req1 and req2 valid simultaneously in IDLE → req1 granted; req2 granted only after req1's note plus the gap.
- req2 playing DO dur 100; req0 asserts FA dur 5 at tick 40 → `abort[2]` and `req_ready[0]` in the same cycle; `note_out` switches 4→1 with no 0 cycle; `done[0]` after 5 ticks.
- PREEMPT=0 with the same stimulus → req0 waits until req2 is done plus the gap.
- dur=0 → plays 1 tick. A tick coincident with the grant is ignored: verify exactly dur ticks for dur=1 and dur=511.
- `enable` dropped mid-PLAY → `abort[owner]`, `note_out`=0 next cycle, no ready while low. Asynchronous `rst_n` pulse mid-GAP → all outputs at reset values immediately.
